// File: rtl/gptim_pkg.sv
// -----------------------------------------------------------------------------
// gptim_pkg
//   Shared definitions for the general-purpose timer channel.
//
//   Contents:
//     - GPTIM_CNT_W_DEF / GPTIM_PSC_W_DEF : default counter and prescaler widths
//     - gptim_mode_e                      : counting mode encoding
//     - gptim_decode_mode()               : maps the raw 2-bit mode field onto
//                                           gptim_mode_e (the unused code 2'b11
//                                           behaves as up-counting)
// -----------------------------------------------------------------------------
package gptim_pkg;

    localparam int GPTIM_CNT_W_DEF = 16;
    localparam int GPTIM_PSC_W_DEF = 16;

    typedef enum logic [1:0] {
        GPTIM_MODE_UP     = 2'b00,
        GPTIM_MODE_DOWN   = 2'b01,
        GPTIM_MODE_CENTER = 2'b10
    } gptim_mode_e;

    function automatic gptim_mode_e gptim_decode_mode(input logic [1:0] raw);
        case (raw)
            2'b01:   return GPTIM_MODE_DOWN;
            2'b10:   return GPTIM_MODE_CENTER;
            default: return GPTIM_MODE_UP;
        endcase
    endfunction

endpackage

// File: rtl/gptim_prescaler.sv
// -----------------------------------------------------------------------------
// gptim_prescaler
//   Divides the channel clock by psc_sh while the channel runs. A divisor of 0
//   behaves as 1 (tick every cycle).
//
//   Ports:
//     ch_clk  in   channel clock
//     ch_rst  in   synchronous, active-high reset
//     psc_sh  in   shadowed prescaler divisor
//     run     in   channel running; pcnt is held at 0 while low
//     clear   in   restart the prescaler period (stop / force update)
//     tick    out  combinational: running and pcnt at the last step of the period
// -----------------------------------------------------------------------------
module gptim_prescaler
    import gptim_pkg::*;
#(
    parameter int PSC_W = GPTIM_PSC_W_DEF
) (
    input  logic             ch_clk,
    input  logic             ch_rst,
    input  logic [PSC_W-1:0] psc_sh,
    input  logic             run,
    input  logic             clear,
    output logic             tick
);

    logic [PSC_W-1:0] pcnt;
    logic [PSC_W-1:0] psc_last;

    // Last prescaler step; divisor 0 collapses to the same value as divisor 1.
    assign psc_last = (psc_sh == '0) ? '0 : psc_sh - PSC_W'(1);
    assign tick     = run && (pcnt == psc_last);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours regardless of block ordering.
    // NOTE: the reset branch is synchronous: ch_rst is only looked at on the
    // rising clock edge, so it is not in the sensitivity list.
    always_ff @(posedge ch_clk) begin
        if (ch_rst) begin
            pcnt <= '0;
        end else if (clear || !run || pcnt >= psc_last) begin
            // >= also recovers cleanly if psc_sh shrinks below the live count.
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PSC_W'(1);
        end
    end

endmodule

// File: rtl/gptim_ch.sv
// -----------------------------------------------------------------------------
// gptim_ch
//   General-purpose timer channel: prescaled up / down / center-aligned counter
//   with shadowed configuration, continuous or one-pulse operation and an
//   optional compare/PWM stage.
//
//   Build option:
//     GPTIM_CH_CMP_EN  defined   : ccr shadow, compare pulse and PWM output
//                      undefined : int_status_ch_cmp and ch_pwm_out tied to 0,
//                                  r_ccr ignored
//
//   Ports:
//     ch_clk, ch_rst        clock, synchronous active-high reset
//     ch_tim_enable         run request; rising edge starts, low stops
//     ch_auto_reload        1 continuous, 0 one-pulse
//     ch_force_update       reload shadows and restart the period
//     r_mode/r_psc/r_arr    mode, prescaler, auto-reload (shadowed)
//     r_startcnt            low bound of the count (used live)
//     r_ccr                 compare value (shadowed, compare build only)
//     ch_cnt, ch_dir        registered count and direction (1 = counting down)
//     ch_running            counter active
//     int_status_ch_reload  one-cycle update pulse, aligned with the reloaded count
//     int_status_ch_cmp     one-cycle compare pulse
//     ch_pwm_out            running && (cnt < ccr), registered
// -----------------------------------------------------------------------------
module gptim_ch
    import gptim_pkg::*;
#(
    parameter int CNT_W = GPTIM_CNT_W_DEF,
    parameter int PSC_W = GPTIM_PSC_W_DEF
) (
    input  logic             ch_clk,
    input  logic             ch_rst,
    input  logic             ch_tim_enable,
    input  logic             ch_auto_reload,
    input  logic             ch_force_update,
    input  logic [1:0]       r_mode,
    input  logic [PSC_W-1:0] r_psc,
    input  logic [CNT_W-1:0] r_arr,
    input  logic [CNT_W-1:0] r_startcnt,
    input  logic [CNT_W-1:0] r_ccr,
    output logic [CNT_W-1:0] ch_cnt,
    output logic             ch_dir,
    output logic             ch_running,
    output logic             int_status_ch_reload,
    output logic             int_status_ch_cmp,
    output logic             ch_pwm_out
);

    // Value the count starts a period from. Down mode starts at the top of the
    // range, except for a degenerate range where the count is pinned to start.
    function automatic logic [CNT_W-1:0] init_cnt(
        input gptim_mode_e      mode,
        input logic [CNT_W-1:0] arr,
        input logic [CNT_W-1:0] start
    );
        return (mode == GPTIM_MODE_DOWN && start < arr) ? arr : start;
    endfunction

    // Registered state
    logic             running_q;
    logic             dir_q;
    logic             en_q;
    logic             reload_q;
    logic [CNT_W-1:0] cnt_q;
    gptim_mode_e      mode_sh;
    logic [PSC_W-1:0] psc_sh;
    logic [CNT_W-1:0] arr_sh;

    // Next-state and control
    logic             tick;
    logic             start_edge;
    logic             stop_req;
    logic             load_sh;
    logic             update_evt;
    logic             tick_eff;
    logic             running_d;
    logic             dir_d;
    logic [CNT_W-1:0] cnt_d;
    gptim_mode_e      new_mode;
    logic [CNT_W-1:0] new_init;

    gptim_prescaler #(
        .PSC_W (PSC_W)
    ) u_prescaler (
        .ch_clk (ch_clk),
        .ch_rst (ch_rst),
        .psc_sh (psc_sh),
        .run    (running_q),
        .clear  (!ch_tim_enable || ch_force_update),
        .tick   (tick)
    );

    assign start_edge = ch_tim_enable && !en_q;
    assign stop_req   = running_q && !ch_tim_enable;

    // Every reload point takes its values from r_*, so the starting count of
    // the next period is derived from the values about to enter the shadows.
    assign new_mode   = gptim_decode_mode(r_mode);
    assign new_init   = init_cnt(new_mode, r_arr, r_startcnt);

    always_comb begin
        // NOTE: every variable gets a default before any branch so the block
        // stays purely combinational and no latch is inferred.
        running_d  = running_q;
        dir_d      = dir_q;
        cnt_d      = cnt_q;
        load_sh    = 1'b0;
        update_evt = 1'b0;
        tick_eff   = 1'b0;

        if (start_edge) begin
            // A coincident force update adds nothing: start already reloads.
            running_d = 1'b1;
            load_sh   = 1'b1;
            cnt_d     = new_init;
            dir_d     = (new_mode == GPTIM_MODE_DOWN);
        end else if (stop_req) begin
            running_d = 1'b0;
            cnt_d     = new_init;
            dir_d     = 1'b0;
        end else if (ch_force_update) begin
            load_sh = 1'b1;
            if (running_q) begin
                cnt_d = new_init;
                dir_d = (new_mode == GPTIM_MODE_DOWN);
            end
        end else if (tick) begin
            tick_eff = 1'b1;
            if (r_startcnt >= arr_sh) begin
                update_evt = 1'b1;
            end else begin
                case (mode_sh)
                    GPTIM_MODE_DOWN: begin
                        if (cnt_q == r_startcnt) update_evt = 1'b1;
                        else                     cnt_d = cnt_q - CNT_W'(1);
                    end
                    GPTIM_MODE_CENTER: begin
                        if (!dir_q) begin
                            if (cnt_q != arr_sh) begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end else if (arr_sh - CNT_W'(1) == r_startcnt) begin
                                // One-step range: the turn-around lands on the
                                // bottom, which is where updates live.
                                update_evt = 1'b1;
                            end else begin
                                dir_d = 1'b1;
                                cnt_d = arr_sh - CNT_W'(1);
                            end
                        end else begin
                            if (cnt_q == r_startcnt + CNT_W'(1)) update_evt = 1'b1;
                            else                                 cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        if (cnt_q == arr_sh) update_evt = 1'b1;
                        else                 cnt_d = cnt_q + CNT_W'(1);
                    end
                endcase
            end

            if (update_evt) begin
                load_sh = 1'b1;
                cnt_d   = new_init;
                if (ch_auto_reload) begin
                    dir_d = (new_mode == GPTIM_MODE_DOWN);
                end else begin
                    running_d = 1'b0;
                    dir_d     = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge ch_clk) begin
        if (ch_rst) begin
            running_q <= 1'b0;
            dir_q     <= 1'b0;
            en_q      <= 1'b0;
            reload_q  <= 1'b0;
            cnt_q     <= '0;
            mode_sh   <= GPTIM_MODE_UP;
            psc_sh    <= '0;
            arr_sh    <= '0;
        end else begin
            running_q <= running_d;
            dir_q     <= dir_d;
            en_q      <= ch_tim_enable;
            reload_q  <= update_evt;
            cnt_q     <= cnt_d;
            if (load_sh) begin
                mode_sh <= new_mode;
                psc_sh  <= r_psc;
                arr_sh  <= r_arr;
            end
        end
    end

    assign ch_cnt               = cnt_q;
    assign ch_dir               = dir_q;
    assign ch_running           = running_q;
    assign int_status_ch_reload = reload_q;

`ifdef GPTIM_CH_CMP_EN
    logic [CNT_W-1:0] ccr_sh;
    logic [CNT_W-1:0] ccr_d;
    logic             cmp_q;
    logic             pwm_q;

    // Compare against the ccr that will be live alongside the new count.
    assign ccr_d = load_sh ? r_ccr : ccr_sh;

    always_ff @(posedge ch_clk) begin
        if (ch_rst) begin
            ccr_sh <= '0;
            cmp_q  <= 1'b0;
            pwm_q  <= 1'b0;
        end else begin
            ccr_sh <= ccr_d;
            cmp_q  <= tick_eff && (cnt_d == ccr_d);
            pwm_q  <= running_d && (cnt_d < ccr_d);
        end
    end

    assign int_status_ch_cmp = cmp_q;
    assign ch_pwm_out        = pwm_q;
`else
    logic unused_cmp;
    assign unused_cmp        = ^{r_ccr, tick_eff};
    assign int_status_ch_cmp = 1'b0;
    assign ch_pwm_out        = 1'b0;
`endif

endmodule

// File: tb/tb_gptim_ch.sv
`timescale 1ns/1ps
module tb_gptim_ch;
    import gptim_pkg::*;

    localparam int CNT_W = 16;
    localparam int PSC_W = 16;
`ifdef GPTIM_CH_CMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    logic             ch_clk = 1'b0;
    logic             ch_rst;
    logic             ch_tim_enable;
    logic             ch_auto_reload;
    logic             ch_force_update;
    logic [1:0]       r_mode;
    logic [PSC_W-1:0] r_psc;
    logic [CNT_W-1:0] r_arr;
    logic [CNT_W-1:0] r_startcnt;
    logic [CNT_W-1:0] r_ccr;
    logic [CNT_W-1:0] ch_cnt;
    logic             ch_dir;
    logic             ch_running;
    logic             int_status_ch_reload;
    logic             int_status_ch_cmp;
    logic             ch_pwm_out;

    gptim_ch #(
        .CNT_W (CNT_W),
        .PSC_W (PSC_W)
    ) dut (
        .ch_clk               (ch_clk),
        .ch_rst               (ch_rst),
        .ch_tim_enable        (ch_tim_enable),
        .ch_auto_reload       (ch_auto_reload),
        .ch_force_update      (ch_force_update),
        .r_mode               (r_mode),
        .r_psc                (r_psc),
        .r_arr                (r_arr),
        .r_startcnt           (r_startcnt),
        .r_ccr                (r_ccr),
        .ch_cnt               (ch_cnt),
        .ch_dir               (ch_dir),
        .ch_running           (ch_running),
        .int_status_ch_reload (int_status_ch_reload),
        .int_status_ch_cmp    (int_status_ch_cmp),
        .ch_pwm_out           (ch_pwm_out)
    );

    always #5 ch_clk = ~ch_clk;

    // Scoreboard entry: outputs expected once the clock counter reaches due.
    typedef struct {
        int               due;
        string            tag;
        logic [CNT_W-1:0] cnt;
        logic [4:0]       flags;   // {dir, running, reload, cmp, pwm}
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Expected counts for the shadowing / force-update sequence.
    int   sh_cnt[18] = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 5, 0, 1, 2, 0, 1, 2, 0, 1};

    always @(posedge ch_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge ch_clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check({e.tag, " cnt"}, 32'(ch_cnt), 32'(e.cnt));
            check({e.tag, " flags"},
                  32'({ch_dir, ch_running, int_status_ch_reload, int_status_ch_cmp, ch_pwm_out}),
                  32'(e.flags));
        end
    end

    // Inputs are already set for the coming edge; queue what that edge must
    // produce and advance one cycle. cmp/pwm expectations follow the compare
    // rules directly from the expected count, tick and ccr.
    task automatic step(input string tag, input logic [CNT_W-1:0] cnt,
                        input logic dir, input logic run, input logic rld,
                        input logic ticked, input logic [CNT_W-1:0] ccr);
        exp_t e;
        logic cmp;
        logic pwm;
        cmp     = CMP_EN && ticked && (cnt == ccr);
        pwm     = CMP_EN && run && (cnt < ccr);
        e.due   = cyc + 1;
        e.tag   = tag;
        e.cnt   = cnt;
        e.flags = {dir, run, rld, cmp, pwm};
        sb.push_back(e);
        @(negedge ch_clk);
        #1;
    endtask

    task automatic set_cfg(input logic [1:0] mode, input int psc, input int arr,
                           input int start, input int ccr, input logic auto_rl);
        r_mode         = mode;
        r_psc          = PSC_W'(psc);
        r_arr          = CNT_W'(arr);
        r_startcnt     = CNT_W'(start);
        r_ccr          = CNT_W'(ccr);
        ch_auto_reload = auto_rl;
    endtask

    initial begin
        ch_rst          = 1'b1;
        ch_tim_enable   = 1'b0;
        ch_force_update = 1'b0;
        set_cfg(2'b00, 4, 3, 0, 2, 1'b1);
        @(negedge ch_clk);
        #1;

        // Reset state
        step("reset", '0, 0, 0, 0, 0, 2);
        step("reset", '0, 0, 0, 0, 0, 2);
        ch_rst = 1'b0;
        step("idle", '0, 0, 0, 0, 0, 2);

        // Up, continuous, psc=4: four cycles per count, reload every 16 cycles
        ch_tim_enable = 1'b1;
        for (int k = 0; k < 42; k++)
            step("up", CNT_W'((k / 4) % 4), 0, 1, k > 0 && k % 16 == 0, k > 0 && k % 4 == 0, 2);
        // Stop mid-count (count is 2): back to start next cycle, no pulse
        ch_tim_enable = 1'b0;
        step("stop_up", '0, 0, 0, 0, 0, 2);
        step("stop_up", '0, 0, 0, 0, 0, 2);

        // Down, psc=2, range 1..4: period (4-1+1)*2 = 8
        set_cfg(2'b01, 2, 4, 1, 3, 1'b1);
        ch_tim_enable = 1'b1;
        for (int k = 0; k < 20; k++)
            step("down", CNT_W'(4 - (k / 2) % 4), 1, 1, k > 0 && k % 8 == 0, k > 0 && k % 2 == 0, 3);
        ch_tim_enable = 1'b0;
        step("stop_down", CNT_W'(4), 0, 0, 0, 0, 3);

        // One-pulse, run twice
        set_cfg(2'b00, 1, 5, 0, 2, 1'b0);
        for (int pass = 0; pass < 2; pass++) begin
            ch_tim_enable = 1'b1;
            for (int k = 0; k < 6; k++)
                step("opm", CNT_W'(k), 0, 1, 0, k > 0, 2);
            step("opm_end", '0, 0, 0, 1, 1, 2);
            step("opm_hold", '0, 0, 0, 0, 0, 2);
            step("opm_hold", '0, 0, 0, 0, 0, 2);
            ch_tim_enable = 1'b0;
            step("opm_idle", '0, 0, 0, 0, 0, 2);
        end

        // Center, range 0..3: 0,1,2,3,2,1 repeating, dir high on the way down
        set_cfg(2'b10, 1, 3, 0, 2, 1'b1);
        ch_tim_enable = 1'b1;
        for (int k = 0; k < 21; k++) begin
            int ph;
            ph = k % 6;
            step("center", CNT_W'(ph <= 3 ? ph : 6 - ph), ph >= 4, 1, k > 0 && ph == 0, k > 0, 2);
        end
        ch_tim_enable = 1'b0;
        step("stop_center", '0, 0, 0, 0, 0, 2);

        // Shadowing: arr 3->5 mid-period, then force update with arr=2
        set_cfg(2'b00, 1, 3, 0, 2, 1'b1);
        ch_tim_enable = 1'b1;
        for (int k = 0; k < 18; k++) begin
            if (k == 2) r_arr = CNT_W'(5);
            if (k == 13) begin
                r_arr           = CNT_W'(2);
                ch_force_update = 1'b1;
            end
            if (k == 14) ch_force_update = 1'b0;
            step("shadow", CNT_W'(sh_cnt[k]), 0, 1, k == 4 || k == 10 || k == 16, k > 0 && k != 13, 2);
        end
        ch_tim_enable = 1'b0;
        step("stop_shadow", '0, 0, 0, 0, 0, 2);

        // Degenerate range: start == arr, count pinned, every tick updates
        set_cfg(2'b00, 2, 3, 3, 3, 1'b1);
        ch_tim_enable = 1'b1;
        for (int k = 0; k < 8; k++)
            step("degen", CNT_W'(3), 0, 1, k > 0 && k % 2 == 0, k > 0 && k % 2 == 0, 3);
        ch_tim_enable = 1'b0;
        step("stop_degen", CNT_W'(3), 0, 0, 0, 0, 3);

        // Mode 2'b11 behaves as up; then reset while running
        set_cfg(2'b11, 1, 2, 0, 1, 1'b1);
        ch_tim_enable = 1'b1;
        for (int k = 0; k < 7; k++)
            step("mode3", CNT_W'(k % 3), 0, 1, k > 0 && k % 3 == 0, k > 0, 1);
        ch_rst        = 1'b1;
        ch_tim_enable = 1'b0;
        step("rst_run", '0, 0, 0, 0, 0, 1);
        ch_rst = 1'b0;
        step("post_rst", '0, 0, 0, 0, 0, 1);

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gptim_ch.md
# gptim_ch

Parametrised general-purpose timer channel, the successor to the basic timer channel. It adds configurable counter and prescaler widths, up, down and center-aligned counting, and one-pulse operation. Period, prescaler, compare and mode configuration are shadowed and take effect only at update events. An optional compare/PWM stage is included. It sits under the timer top's register block, one instance per channel, and feeds the timer's interrupt aggregator.

## Interface
- CNT_W, 16, counter, ARR, startcnt and CCR width
- PSC_W, 16, prescaler width
- ch_clk  in  1  channel clock
- ch_rst  in  1  synchronous, active-high reset
- ch_tim_enable  in  1  run request; a rising edge starts, low stops immediately
- ch_auto_reload  in  1  1: continuous; 0: one-pulse, stops after the first update event
- ch_force_update  in  1  software update: reload shadows, restart the period
- r_mode  in  2  00 up, 01 down, 10 center, 11 treated as up
- r_psc  in  PSC_W  prescaler divisor; 0 is treated as 1
- r_arr  in  CNT_W  auto-reload value
- r_startcnt  in  CNT_W  low bound of the count
- r_ccr  in  CNT_W  compare value
- ch_cnt  out  CNT_W  current count (registered)
- ch_dir  out  1  0 counting up, 1 counting down
- ch_running  out  1  counter active
- int_status_ch_reload  out  1  one-cycle update pulse
- int_status_ch_cmp  out  1  one-cycle compare pulse
- ch_pwm_out  out  1  PWM level

## Operation
- **Shadows.** mode_sh, psc_sh, arr_sh and ccr_sh load from the r_* inputs:
  - at the start edge,
  - at every update event,
  - on ch_force_update.
  - Writes between these points have no effect on the running period.
- **Prescaler.** pcnt counts 0..psc_sh-1 while running. `tick` = running && pcnt==psc_sh-1. pcnt is held at 0 when idle.
- **Up mode.**
  - On tick: cnt+1.
  - On tick with cnt==arr_sh: update event, cnt <= startcnt.
- **Down mode.**
  - Initial value is arr_sh. On tick: cnt-1.
  - On tick with cnt==startcnt: update event, cnt <= arr_sh.
- **Center mode.**
  - Counts up from startcnt; on tick at arr_sh, dir <= 1 and cnt <= arr_sh-1.
  - Counts down; on tick at startcnt+1, cnt <= startcnt, dir <= 0, and an update event occurs. Updates happen at the bottom only.
- **Degenerate range.** If startcnt >= arr_sh: cnt is held at startcnt, and every tick is an update event.
- **One-pulse.** If ch_auto_reload==0 at an update event: running <= 0 and cnt goes to its initial value. Restart needs a new rising edge of ch_tim_enable.
- **Stop.** ch_tim_enable low: running <= 0 on the next edge, pcnt <= 0, cnt <= initial value of r_mode (r_arr for down, r_startcnt otherwise), dir <= 0.
- **Force update while running.** ch_force_update: shadows reload, pcnt <= 0, cnt <= initial value, no interrupt pulse.
- **Simultaneous events.**
  - Stop has priority over force update.
  - Force update has priority over tick.
  - A start edge coincident with ch_force_update is a plain start.
- **Arithmetic.** All counter arithmetic is unsigned at CNT_W. No wrap past 0 or all-ones is reachable within range.

## Timing
- **Reset.** ch_rst high at an edge sets all outputs to 0 and clears the shadows, pcnt and the state, regardless of activity.
- **Start.** ch_tim_enable rises, sampled at edge N: ch_running=1 after N. The first tick is psc_sh cycles later.
- **Update pulse.** int_status_ch_reload is high for exactly the one cycle in which ch_cnt first shows the reloaded value.
- **Up-mode period.** (arr_sh-startcnt+1)*psc_sh cycles.
- **Center-mode period.** 2*(arr_sh-startcnt)*psc_sh cycles.
- **Shadow timing.** New r_* values load together with the update pulse and govern the next period.

## Configuration
- GPTIM_CH_CMP_EN defined:
  - int_status_ch_cmp pulses one cycle after a tick that leaves cnt==ccr_sh.
  - ch_pwm_out = running && (cnt < ccr_sh), registered alongside ch_cnt.
  - ccr_sh exists.
- Undefined:
  - int_status_ch_cmp and ch_pwm_out are tied to 0.
  - No ccr_sh or comparator logic.
  - r_ccr is unused.

## Structure
- Package gptim_pkg holds:
  - mode constants GPTIM_MODE_UP=2'b00, GPTIM_MODE_DOWN=2'b01, GPTIM_MODE_CENTER=2'b10,
  - default widths.
- Sub-module gptim_prescaler (PSC_W): takes psc_sh, run and clear; produces tick.
- The counter, direction, shadows and compare logic live in gptim_ch.

## Test plan
- **Up, continuous.** Up, psc=4, arr=3, start=0, auto reload -> ch_cnt steps 0,1,2,3, 4 cycles each; reload pulse every 16 cycles.
- **One-pulse.** Up, psc=1, arr=5, auto reload off -> one reload pulse after 6 cycles, then ch_running=0 and ch_cnt=0; a second rising edge runs again.
- **Center.** psc=1, arr=3, start=0 -> ch_cnt 0,1,2,3,2,1,0,1…; ch_dir high during 2,1; reload on each return to 0; period 6.
- **Shadowing.** Change r_arr 3->5 mid-period -> the current period stays 4 ticks; the next period is 6 ticks, starting with the update pulse.
- **PWM (GPTIM_CH_CMP_EN).** Up, psc=1, arr=3, ccr=2 -> ch_pwm_out repeats 1,1,0,0; cmp pulse once per period.
- **Stop and reset.** Drop ch_tim_enable mid-count -> ch_cnt returns to start next cycle, no pulse. Assert ch_rst while running -> all outputs 0 next cycle.
